// File: rtl/jtag_shift_master.sv
// ---------------------------------------------------------------------------
// jtag_shift_master
//
// Purpose:
//   Drives a JTAG TAP with commands taken from a valid/ready command port.
//   Each command is either a TMS sequence (type 0) or a data shift (type 1).
//   Up to 32 bits are clocked per command, LSB first. TDO is captured on
//   every TCK rising edge and returned on a valid/ready response port.
//   TCK is generated from clk_i with a half-period of CLK_DIV clk_i cycles.
//
// Parameters:
//   CLK_DIV      TCK half-period in clk_i cycles (legal range 1..255).
//
// Ports:
//   clk_i        sole clock
//   rst_i        asynchronous active-high reset
//   cmd_valid_i  command offered
//   cmd_ready_o  high only in IDLE; command accepted on valid && ready
//   cmd_type_i   0 = TMS sequence, 1 = data shift
//   cmd_len_i    bit count (33..63 are treated as 32, 0 shifts nothing)
//   cmd_data_i   TMS bits (type 0) or TDI bits (type 1), LSB first
//   cmd_exit_i   type 1 only: TMS=1 on the last bit
//   rsp_valid_o  response held (high only in RESP)
//   rsp_ready_i  response consumed on valid && ready
//   rsp_data_o   captured TDO bits, LSB first, bits above len are 0
//   jtag_tck_o   TCK
//   jtag_tms_o   TMS
//   jtag_tdi_o   TDI
//   jtag_tdo_i   TDO from the target TAP
// ---------------------------------------------------------------------------
module jtag_shift_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_type_i,
    input  logic [5:0]  cmd_len_i,
    input  logic [31:0] cmd_data_i,
    input  logic        cmd_exit_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        jtag_tck_o,
    output logic        jtag_tms_o,
    output logic        jtag_tdi_o,
    input  logic        jtag_tdo_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_RESP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_tck;
    logic        r_tms;
    logic        r_tdi;

    // Command captured on accept; the input bus is ignored afterwards.
    logic        r_type;
    logic        r_exit;
    logic [5:0]  r_len;
    logic [31:0] r_data;

    // Bit index never exceeds 31 and the divider never exceeds CLK_DIV-1,
    // so neither counter can wrap within a command.
    logic [5:0]  r_bit;
    logic [7:0]  r_div;

    logic [5:0]  w_len_eff;
    logic        w_first_tms;
    logic        w_first_tdi;
    logic        w_div_done;
    logic        w_last_bit;
    logic [5:0]  w_next_bit;
    logic        w_next_data;
    logic        w_next_tms;
    logic        w_next_tdi;

    // Lengths beyond the 32-bit data word are clamped to a full word.
    assign w_len_eff   = (cmd_len_i > 6'd32) ? 6'd32 : cmd_len_i;

    // Pin values for bit 0, taken straight from the command being accepted.
    assign w_first_tms = cmd_type_i ? (cmd_exit_i && (w_len_eff == 6'd1))
                                    : cmd_data_i[0];
    assign w_first_tdi = cmd_type_i & cmd_data_i[0];

    assign w_div_done  = (r_div == DIV_LAST);
    assign w_last_bit  = (r_bit == r_len - 6'd1);

    // Pin values for the following bit, set up while leaving HIGH of bit i.
    assign w_next_bit  = r_bit + 6'd1;
    assign w_next_data = r_data[w_next_bit[4:0]];
    assign w_next_tms  = r_type ? (r_exit && (w_next_bit == r_len - 6'd1))
                                : w_next_data;
    assign w_next_tdi  = r_type & w_next_data;

    // NOTE: every register here is updated with <= so all state changes
    // take effect together at the clock edge, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_type      <= 1'b0;
            r_exit      <= 1'b0;
            r_len       <= '0;
            r_data      <= '0;
            r_bit       <= '0;
            r_div       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_type      <= cmd_type_i;
                        r_exit      <= cmd_exit_i;
                        r_len       <= w_len_eff;
                        r_data      <= cmd_data_i;
                        r_bit       <= '0;
                        r_div       <= '0;
                        r_rsp_data  <= '0;
                        r_cmd_ready <= 1'b0;
                        if (w_len_eff == 6'd0) begin
                            // Nothing to shift: answer immediately, pins untouched.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= S_LOW;
                            r_tck   <= 1'b0;
                            r_tms   <= w_first_tms;
                            r_tdi   <= w_first_tdi;
                        end
                    end
                end

                S_LOW: begin
                    if (w_div_done) begin
                        // This edge is the TCK rising edge: capture TDO now.
                        r_div                   <= '0;
                        r_rsp_data[r_bit[4:0]]  <= jtag_tdo_i;
                        r_tck                   <= 1'b1;
                        r_state                 <= S_HIGH;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_HIGH: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        r_tck <= 1'b0;
                        if (w_last_bit) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_bit   <= w_next_bit;
                            r_tms   <= w_next_tms;
                            r_tdi   <= w_next_tdi;
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_RESP: begin
                    // cmd_ready stays low through the handshake cycle, so a
                    // new command can only be taken from the following cycle.
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_tck       <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign jtag_tck_o  = r_tck;
    assign jtag_tms_o  = r_tms;
    assign jtag_tdi_o  = r_tdi;

endmodule

// File: doc/jtag_shift_master.md
JTAG_SHIFT_MASTER -- requirements
Module: jtag_shift_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: TCK half-period in clk_i cycles; legal range 1..255.
REQ-002 SHALL have ports, listed as name, direction, width, meaning:
- clk_i, in, 1: sole clock.
- rst_i, in, 1: reset, asynchronous, active-high.
REQ-003 SHALL have command-side ports:
- cmd_valid_i, in, 1: command offered.
- cmd_ready_o, out, 1: command accepted when both valid and ready are high.
- cmd_type_i, in, 1: 0 = TMS sequence, 1 = data shift.
- cmd_len_i, in, 6: bit count.
- cmd_data_i, in, 32: TMS bits (type 0) or TDI bits (type 1), LSB first.
- cmd_exit_i, in, 1: type 1 only; TMS=1 on the last bit.
REQ-004 SHALL have response-side ports:
- rsp_valid_o, out, 1: response held.
- rsp_ready_i, in, 1: response consumed when both valid and ready are high.
- rsp_data_o, out, 32: captured TDO bits, LSB first.
REQ-005 SHALL have JTAG ports:
- jtag_tck_o, out, 1: TCK.
- jtag_tms_o, out, 1: TMS.
- jtag_tdi_o, out, 1: TDI.
- jtag_tdo_i, in, 1: TDO from the target TAP.

Function
REQ-006 SHALL implement the FSM IDLE -> LOW -> HIGH -> (LOW | RESP) -> IDLE.
REQ-007 SHALL drive cmd_ready_o=1 only in IDLE and rsp_valid_o=1 only in RESP.
REQ-008 SHALL register cmd_type, len, data and exit on accept; later input changes SHALL be ignored.
REQ-009 SHALL treat an effective length of 33..63 as 32.
REQ-010 SHALL, for length 0, go IDLE -> RESP with rsp_data_o=0 and generate no TCK edge.
REQ-011 SHALL, per bit i (0..len-1), spend CLK_DIV cycles in LOW (tck=0), then CLK_DIV cycles in HIGH (tck=1).
REQ-012 SHALL update jtag_tms_o and jtag_tdi_o at the first LOW cycle of bit i and hold them through that bit's HIGH phase.
REQ-013 SHALL, for type 0, drive tms=cmd_data[i] and tdi=0.
REQ-014 SHALL, for type 1, drive tdi=cmd_data[i] and tms=(cmd_exit && i==len-1).
REQ-015 SHALL sample jtag_tdo_i into rsp bit i on the clk_i edge that ends the last LOW cycle of bit i (the TCK rising edge), for both command types.
REQ-016 SHALL leave rsp_data_o bits [31:len] at 0.
REQ-017 SHALL, after the last HIGH cycle, enter RESP with tck=0.
REQ-018 SHALL give a fixed latency: accept at edge 0, rsp_valid_o high from cycle 2*CLK_DIV*len+1.
REQ-019 SHALL hold rsp_valid_o and rsp_data_o stable in RESP until rsp_ready_i=1; the next cycle SHALL be IDLE.
REQ-020 SHALL NOT accept a new command in the cycle of the response handshake.
REQ-021 SHALL, in IDLE and RESP, hold tck=0 and hold tms/tdi at their last driven values, so the TAP state is unchanged.
REQ-022 SHALL keep its bit counter 6 bits wide and its divider counter 8 bits wide; neither SHALL wrap during a command.

Reset
REQ-023 SHALL, with rst_i high and asynchronously to clk_i, force state=IDLE, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, jtag_tck_o=0, jtag_tms_o=1, jtag_tdi_o=0.
REQ-024 SHALL, on reset during a command, abort it with no response, and SHALL produce no further TCK edge after reset release until a new command is accepted.
REQ-025 SHALL resume normal operation on the first clk_i edge after rst_i deasserts.

Verification
REQ-026 With CLK_DIV=2 and a type 0 command (len 5, data 0x1F): 5 TCK pulses, TMS=1 at every rising edge, rsp_valid_o high at cycle 21, tdi=0 throughout.
REQ-027 With TDO looped to TDI and a type 1 command (len 8, data 0xA5, exit 1): rsp_data_o=0x000000A5, TMS=0 at bits 0..6 and 1 at bit 7.
REQ-028 With loopback and a type 1 command (len 32, data 0xDEADBEEF, CLK_DIV=1): rsp_data_o=0xDEADBEEF at cycle 65.
REQ-029 A command with len 0: rsp_valid_o at cycle 1, rsp_data_o=0, no TCK edge.
REQ-030 With rsp_ready_i held low for 10 cycles in RESP: rsp_valid_o and rsp_data_o stable, cmd_ready_o=0; IDLE one cycle after rsp_ready_i rises.
REQ-031 With rst_i asserted mid-shift during bit 3, HIGH phase: tck=0, tms=1, tdi=0, cmd_ready_o=1 without a clk_i edge, and no response is issued.
